sfp_link_mgr: RTL



---
 rtl/sfp_link_mgr.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sfp_link_mgr.sv
// sfp_link_mgr: per-cage SFP management. It synchronises and debounces mod_abs and
// rxlos, sequences tx_dis through an insertion settle delay, and reports
// present/link status, a link-loss event count and an LED drive.
module sfp_link_mgr #(
  parameter int unsigned DEBOUNCE_CYC     = 100000,
  parameter int unsigned INSERT_DELAY_CYC = 30000000,
  parameter int unsigned BLINK_CYC        = 25000000,
  parameter int unsigned LOS_CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mod_abs_i,
  input  logic                 rxlos_i,
  input  logic                 tx_dis_req_i,
  input  logic                 los_cnt_clr_i,
  output logic                 tx_dis_o,
  output logic                 present_o,
  output logic                 link_ok_o,
  output logic [2:0]           state_o,
  output logic [LOS_CNT_W-1:0] los_cnt_o,
  output logic                 led_o
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TMR_W = (INSERT_DELAY_CYC > 1) ? $clog2(INSERT_DELAY_CYC) : 1;
  localparam int unsigned BLK_W = $clog2(BLINK_CYC + 1);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_WAIT     = 3'd1,
    ST_NOLINK   = 3'd2,
    ST_LINK     = 3'd3,
    ST_DISABLED = 3'd4
  } state_e;

  // Bit 0 carries mod_abs and bit 1 carries rxlos.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           filt_q, filt_d;
  logic [DB_W-1:0]      db_cnt_q [2];
  logic [DB_W-1:0]      db_cnt_d [2];

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 tx_dis_q, tx_dis_d;
  logic                 present_q, present_d;
  logic                 link_ok_q, link_ok_d;
  logic [LOS_CNT_W-1:0] los_cnt_q, los_cnt_d;
  logic                 led_q, led_d;
  logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;

  logic                 mod_abs_f;
  logic                 rxlos_f;

  assign mod_abs_f = filt_q[0];
  assign rxlos_f   = filt_q[1];

  // Two-stage synchroniser, then debounce: filtered value follows only after DEBOUNCE_CYC differing cycles
  always_comb begin
    sync1_d  = {rxlos_i, mod_abs_i};
    sync2_d  = sync1_q;
    filt_d   = filt_q;
    db_cnt_d = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Link state machine; removal overrides every other transition
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    case (state_q)
      ST_ABSENT: begin
        if (!mod_abs_f) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmr_q == TMR_W'(INSERT_DELAY_CYC - 1)) begin
          state_d = tx_dis_req_i ? ST_DISABLED : ST_NOLINK;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_NOLINK: begin
        if (tx_dis_req_i)  state_d = ST_DISABLED;
        else if (!rxlos_f) state_d = ST_LINK;
      end
      ST_LINK: begin
        if (tx_dis_req_i) state_d = ST_DISABLED;
        else if (rxlos_f) state_d = ST_NOLINK;
      end
      ST_DISABLED: begin
        if (!tx_dis_req_i) state_d = ST_NOLINK;
      end
      default: state_d = ST_ABSENT;
    endcase
    if (mod_abs_f) state_d = ST_ABSENT;
  end

  // Status outputs follow next-state so they line up with state_o
  always_comb begin
    tx_dis_d  = !((state_d == ST_NOLINK) || (state_d == ST_LINK));
    present_d = (state_d != ST_ABSENT);
    link_ok_d = (state_d == ST_LINK);

    los_cnt_d = los_cnt_q;
    if (los_cnt_clr_i) begin
      los_cnt_d = '0;
    end else if ((state_q == ST_LINK) && (state_d == ST_NOLINK) && (los_cnt_q != '1)) begin
      los_cnt_d = los_cnt_q + LOS_CNT_W'(1);
    end

    led_d       = 1'b0;
    blink_cnt_d = '0;
    if (state_d == ST_LINK) begin
      led_d = 1'b1;
    end else if (state_d == ST_NOLINK) begin
      if (state_q != ST_NOLINK) begin
        led_d       = 1'b1;
        blink_cnt_d = BLK_W'(1);
      end else if (blink_cnt_q == BLK_W'(BLINK_CYC)) begin
        led_d       = !led_q;
        blink_cnt_d = BLK_W'(1);
      end else begin
        led_d       = led_q;
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // All state and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      db_cnt_q    <= '{default: '0};
      state_q     <= ST_ABSENT;
      tmr_q       <= '0;
      tx_dis_q    <= 1'b1;
      present_q   <= 1'b0;
      link_ok_q   <= 1'b0;
      los_cnt_q   <= '0;
      led_q       <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      tx_dis_q    <= tx_dis_d;
      present_q   <= present_d;
      link_ok_q   <= link_ok_d;
      los_cnt_q   <= los_cnt_d;
      led_q       <= led_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign tx_dis_o  = tx_dis_q;
  assign present_o = present_q;
  assign link_ok_o = link_ok_q;
  assign state_o   = state_q;
  assign los_cnt_o = los_cnt_q;
  assign led_o     = led_q;

endmodule
